bfm_op_sequencer: RTL and testbench
===================================

# bfm_op_sequencer

Controller that shares the `bfm` operand datapath between two requesters and sequences a fixed-length test run. It sits between the stimulus sources and the `bfm` instance inside the wrapper. It arbitrates operand pairs round-robin, drives `A_s`/`B_s` with an issue strobe, and tracks in-flight operations through the fixed `bfm` latency. It returns each `res_o` result tagged with its requester ID and raises `done_o` once `LENGTH` results have returned.

## Interface
Parameters:
- `DATA_W`, 8: width of operands and result.
- `LENGTH`, 2000: operations per run; must be ≥1.
- `LAT`, 1: `bfm` latency in cycles, from `A_s`/`B_s` presentation to a valid `res_i`; must be ≥1.

Ports (one clock `clk_i`; `reset_i` is synchronous, active-high):
- `clk_i` in 1: clock.
- `reset_i` in 1: synchronous active-high reset.
- `start_i` in 1: run start pulse.
- `req0_valid_i` in 1: requester 0 has an operand pair.
- `req0_a_i` in DATA_W: requester 0 operand A.
- `req0_b_i` in DATA_W: requester 0 operand B.
- `req0_ready_o` out 1: grant/accept for requester 0.
- `req1_valid_i`, `req1_a_i`, `req1_b_i`, `req1_ready_o`: same as requester 0, for requester 1.
- `A_s` out DATA_W: operand A to `bfm`.
- `B_s` out DATA_W: operand B to `bfm`.
- `op_valid_o` out 1: `A_s`/`B_s` carry a new operation this cycle.
- `res_i` in DATA_W: `bfm` `res_o`.
- `rsp_valid_o` out 1: result strobe.
- `rsp_id_o` out 1: requester ID of the result.
- `rsp_data_o` out DATA_W: result value.
- `busy_o` out 1: state is RUN or DRAIN.
- `done_o` out 1: run complete.
- `issued_cnt_o` out 32: operations issued this run.

## Operation
- **FSM states:**
  - IDLE: reset state. On `start_i`, go to RUN and clear both counters.
  - RUN: issue operations. When `issued_cnt == LENGTH`, go to DRAIN.
  - DRAIN: wait for in-flight results. When `rsp_cnt == LENGTH`, go to DONE.
  - DONE: `done_o` = 1. On `start_i`, go to RUN, clear counters and `done_o`.
- **Grant eligibility:** a grant is possible only in RUN with `issued_cnt < LENGTH`.
- **Arbitration:** round-robin between the valid requesters, using a priority pointer `rr`.
  - `rr` resets to 0.
  - After a grant to requester k, `rr` becomes 1-k.
  - A single valid requester is granted regardless of `rr`.
- **Ready:** `reqN_ready_o` is combinational and equals the grant. At most one is high per cycle. A transfer occurs on `valid && ready` at a clock edge.
- **Issue:** on a transfer, the next cycle has:
  - `A_s`/`B_s` = the granted operands;
  - `op_valid_o` = 1;
  - `issued_cnt` incremented.
- **No transfer:** `op_valid_o` = 0 and `A_s`/`B_s` hold their last values.
- **Tag pipeline:** a LAT-deep shift register carries (`op_valid_o`, id). When the tag exits, `res_i` is registered into `rsp_data_o` with `rsp_valid_o` = 1 and `rsp_id_o` = id. `rsp_cnt` (internal, 32-bit) increments on each result.
- **No backpressure:** responses cannot be stalled. `rsp_valid_o` is a single-cycle strobe per result.
- **`start_i` outside IDLE/DONE:** ignored (in RUN and DRAIN).
- **Counter width:** counters are 32-bit unsigned and never exceed LENGTH; no wrap.
- **Reset (including mid-run):**
  - State returns to IDLE; the tag pipeline is cleared.
  - In-flight results are discarded; no `rsp_valid_o` follows.
  - All outputs go to 0: `A_s`, `B_s`, `op_valid_o`, ready, rsp, `busy_o`, `done_o`, `issued_cnt_o`.

## Timing
- Transfer at edge T → `op_valid_o`/`A_s`/`B_s` valid in cycle T+1.
- `res_i` for that operation is sampled in cycle T+1+LAT.
- `rsp_valid_o` is high in cycle T+2+LAT. Handshake-to-response latency is LAT+2 cycles.
- Throughput: one operation per cycle, with back-to-back grants allowed.
- Ready drops combinationally in the cycle `issued_cnt` reaches LENGTH.
- `busy_o` rises the cycle after `start_i` and falls the cycle `done_o` rises.
- `done_o` rises the cycle after the last `rsp_valid_o`.
- `issued_cnt_o` is registered: it reflects transfers up to the previous edge.

## Test plan
- **Reset:** assert `reset_i` for 2 cycles with random inputs → all outputs 0, ready low, state IDLE.
- **Single requester** (`LENGTH`=4, `LAT`=1): `start_i`, then `req0` valid with a=1, b=2 held continuously, `bfm` returns 3.
  - Exactly 4 consecutive transfers and 4 `op_valid_o` cycles with A_s=1, B_s=2.
  - 4 `rsp_valid_o` with id=0, data=3, the first 3 cycles after the first handshake.
  - `done_o`=1 the cycle after the 4th response; `issued_cnt_o`=4.
- **Contention:** both requesters valid continuously, `LENGTH`=6 → grants 0,1,0,1,0,1 and `rsp_id_o` sequence 0,1,0,1,0,1.
- **Bubbles:** `req0` valid only on alternate cycles, `req1` idle → `op_valid_o` alternates 1/0, `A_s` holds during gaps, `issued_cnt_o` increments only on transfers.
- **start_i handling:** pulse `start_i` mid-RUN → ignored, `LENGTH` unchanged. Pulse in DONE → `done_o` clears, counters reset to 0, new run completes.
- **Reset mid-run:** assert `reset_i` after 3 issues with `LAT`=3 outstanding → no `rsp_valid_o` afterwards, outputs 0, IDLE until the next `start_i`.

Source files
------------

// File: rtl/bfm_op_sequencer.sv
// Shares the bfm operand datapath between two requesters: round-robin grant,
// operand issue, a LAT-deep tag pipeline and a fixed-length run controller.
module bfm_op_sequencer #(
  parameter int DATA_W = 8,
  parameter int LENGTH = 2000,
  parameter int LAT    = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              req0_valid_i,
  input  logic [DATA_W-1:0] req0_a_i,
  input  logic [DATA_W-1:0] req0_b_i,
  output logic              req0_ready_o,
  input  logic              req1_valid_i,
  input  logic [DATA_W-1:0] req1_a_i,
  input  logic [DATA_W-1:0] req1_b_i,
  output logic              req1_ready_o,
  output logic [DATA_W-1:0] A_s,
  output logic [DATA_W-1:0] B_s,
  output logic              op_valid_o,
  input  logic [DATA_W-1:0] res_i,
  output logic              rsp_valid_o,
  output logic              rsp_id_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [31:0]       issued_cnt_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]  state;
  logic [31:0] issued_cnt;
  logic [31:0] rsp_cnt;
  logic        rr;
  logic        can_grant;
  logic        gnt0;
  logic        gnt1;
  logic        xfer;
  logic        op_id_p0;
  logic [LAT-1:0] tag_vld_p1;
  logic [LAT-1:0] tag_id_p1;

  // A lone valid requester wins outright; rr only breaks ties.
  always_comb begin
    can_grant = (state == RUN) && (issued_cnt < 32'(LENGTH));
    gnt0      = can_grant && req0_valid_i && (!req1_valid_i || !rr);
    gnt1      = can_grant && req1_valid_i && (!req0_valid_i ||  rr);
    xfer      = gnt0 || gnt1;
  end

  assign req0_ready_o = gnt0;
  assign req1_ready_o = gnt1;
  assign busy_o       = (state == RUN) || (state == DRAIN);
  assign done_o       = (state == DONE);
  assign issued_cnt_o = issued_cnt;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= IDLE;
      issued_cnt  <= '0;
      rsp_cnt     <= '0;
      rr          <= 1'b0;
      op_valid_o  <= 1'b0;
      op_id_p0    <= 1'b0;
      A_s         <= '0;
      B_s         <= '0;
      tag_vld_p1  <= '0;
      tag_id_p1   <= '0;
      rsp_valid_o <= 1'b0;
      rsp_id_o    <= 1'b0;
      rsp_data_o  <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (start_i) begin
          state      <= RUN;
          issued_cnt <= '0;
          rsp_cnt    <= '0;
        end
        RUN:   if (issued_cnt == 32'(LENGTH)) state <= DRAIN;
        DRAIN: if (rsp_cnt == 32'(LENGTH)) state <= DONE;
        default: state <= IDLE;
      endcase

      // Stage p0: issue granted operands; A_s/B_s hold through bubbles.
      op_valid_o <= xfer;
      if (xfer) begin
        A_s        <= gnt0 ? req0_a_i : req1_a_i;
        B_s        <= gnt0 ? req0_b_i : req1_b_i;
        op_id_p0   <= gnt1;
        rr         <= gnt0;
        issued_cnt <= issued_cnt + 32'd1;
      end

      // Stage p1: tag shift register mirrors the bfm latency.
      tag_vld_p1[0] <= op_valid_o;
      tag_id_p1[0]  <= op_id_p0;
      for (int i = 1; i < LAT; i++) begin
        tag_vld_p1[i] <= tag_vld_p1[i-1];
        tag_id_p1[i]  <= tag_id_p1[i-1];
      end

      // Stage p2: capture the bfm result as the matching tag exits.
      rsp_valid_o <= tag_vld_p1[LAT-1];
      if (tag_vld_p1[LAT-1]) begin
        rsp_data_o <= res_i;
        rsp_id_o   <= tag_id_p1[LAT-1];
        rsp_cnt    <= rsp_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_bfm_op_sequencer.sv
// Directed bench for bfm_op_sequencer: one instance with LENGTH=4/LAT=1 and one
// with LENGTH=6/LAT=3, driven in a single linear sequence.
module tb_bfm_op_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       a_rst, a_start, a_v0, a_v1, a_rdy0, a_rdy1, a_opv, a_rspv, a_id, a_busy, a_done;
  logic [7:0] a_a0, a_b0, a_a1, a_b1, a_res, a_As, a_Bs, a_rdata;
  logic [31:0] a_iss;

  logic       b_rst, b_start, b_v0, b_v1, b_rdy0, b_rdy1, b_opv, b_rspv, b_id, b_busy, b_done;
  logic [7:0] b_a0, b_b0, b_a1, b_b1, b_res, b_As, b_Bs, b_rdata;
  logic [31:0] b_iss;

  bfm_op_sequencer #(.DATA_W(8), .LENGTH(4), .LAT(1)) dut_a (
    .clk_i(clk), .reset_i(a_rst), .start_i(a_start),
    .req0_valid_i(a_v0), .req0_a_i(a_a0), .req0_b_i(a_b0), .req0_ready_o(a_rdy0),
    .req1_valid_i(a_v1), .req1_a_i(a_a1), .req1_b_i(a_b1), .req1_ready_o(a_rdy1),
    .A_s(a_As), .B_s(a_Bs), .op_valid_o(a_opv), .res_i(a_res),
    .rsp_valid_o(a_rspv), .rsp_id_o(a_id), .rsp_data_o(a_rdata),
    .busy_o(a_busy), .done_o(a_done), .issued_cnt_o(a_iss)
  );

  bfm_op_sequencer #(.DATA_W(8), .LENGTH(6), .LAT(3)) dut_b (
    .clk_i(clk), .reset_i(b_rst), .start_i(b_start),
    .req0_valid_i(b_v0), .req0_a_i(b_a0), .req0_b_i(b_b0), .req0_ready_o(b_rdy0),
    .req1_valid_i(b_v1), .req1_a_i(b_a1), .req1_b_i(b_b1), .req1_ready_o(b_rdy1),
    .A_s(b_As), .B_s(b_Bs), .op_valid_o(b_opv), .res_i(b_res),
    .rsp_valid_o(b_rspv), .rsp_id_o(b_id), .rsp_data_o(b_rdata),
    .busy_o(b_busy), .done_o(b_done), .issued_cnt_o(b_iss)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_inputs();
    a_start = 1'($urandom); a_v0 = 1'($urandom); a_v1 = 1'($urandom);
    a_a0 = 8'($urandom); a_b0 = 8'($urandom); a_a1 = 8'($urandom); a_b1 = 8'($urandom); a_res = 8'($urandom);
    b_start = 1'($urandom); b_v0 = 1'($urandom); b_v1 = 1'($urandom);
    b_a0 = 8'($urandom); b_b0 = 8'($urandom); b_a1 = 8'($urandom); b_b1 = 8'($urandom); b_res = 8'($urandom);
  endtask

  initial begin
    int rsp_n;
    int exp_iss;

    // Reset for two cycles with random inputs
    a_rst = 1'b1; b_rst = 1'b1;
    randomize_inputs();
    step();
    randomize_inputs();
    step();
    #1;
    chk("rst_a_As", 32'(a_As), 0);       chk("rst_a_Bs", 32'(a_Bs), 0);
    chk("rst_a_opv", 32'(a_opv), 0);     chk("rst_a_rspv", 32'(a_rspv), 0);
    chk("rst_a_rid", 32'(a_id), 0);      chk("rst_a_rdata", 32'(a_rdata), 0);
    chk("rst_a_rdy0", 32'(a_rdy0), 0);   chk("rst_a_rdy1", 32'(a_rdy1), 0);
    chk("rst_a_busy", 32'(a_busy), 0);   chk("rst_a_done", 32'(a_done), 0);
    chk("rst_a_iss", a_iss, 0);
    chk("rst_b_opv", 32'(b_opv), 0);     chk("rst_b_rspv", 32'(b_rspv), 0);
    chk("rst_b_rdy0", 32'(b_rdy0), 0);   chk("rst_b_rdy1", 32'(b_rdy1), 0);
    chk("rst_b_busy", 32'(b_busy), 0);   chk("rst_b_done", 32'(b_done), 0);
    chk("rst_b_iss", b_iss, 0);

    a_rst = 1'b0; b_rst = 1'b0;
    a_start = 0; a_v0 = 0; a_v1 = 0; a_a0 = 0; a_b0 = 0; a_a1 = 0; a_b1 = 0; a_res = 0;
    b_start = 0; b_v0 = 0; b_v1 = 0; b_a0 = 0; b_b0 = 0; b_a1 = 0; b_b1 = 0; b_res = 0;
    step();

    // IDLE grants nothing without a start
    a_v0 = 1'b1;
    #1;
    chk("idle_rdy0", 32'(a_rdy0), 0);
    step();
    chk("idle_opv", 32'(a_opv), 0);
    a_v0 = 1'b0;

    // Single requester, LENGTH=4, LAT=1
    a_start = 1'b1; a_res = 8'd3;
    #1;
    step();
    a_start = 1'b0; a_v0 = 1'b1; a_a0 = 8'd1; a_b0 = 8'd2;
    for (int i = 1; i <= 8; i++) begin
      #1;
      exp_iss = (i <= 1) ? 0 : ((i - 1 > 4) ? 4 : i - 1);
      chk("s_rdy0", 32'(a_rdy0), 32'(i <= 4));
      chk("s_rdy1", 32'(a_rdy1), 0);
      chk("s_opv", 32'(a_opv), 32'(i >= 2 && i <= 5));
      if (i >= 2 && i <= 5) begin
        chk("s_As", 32'(a_As), 1);
        chk("s_Bs", 32'(a_Bs), 2);
      end
      chk("s_rspv", 32'(a_rspv), 32'(i >= 4 && i <= 7));
      if (i >= 4 && i <= 7) begin
        chk("s_rid", 32'(a_id), 0);
        chk("s_rdata", 32'(a_rdata), 3);
      end
      chk("s_iss", a_iss, 32'(exp_iss));
      chk("s_busy", 32'(a_busy), 32'(i <= 7));
      chk("s_done", 32'(a_done), 32'(i == 8));
      step();
    end
    a_v0 = 1'b0;

    // Restart from DONE, then bubbles with a start pulse ignored mid-run
    a_start = 1'b1;
    #1;
    chk("d_done_before", 32'(a_done), 1);
    step();
    rsp_n = 0;
    for (int i = 1; i <= 8; i++) begin
      a_v0 = 1'(i % 2);
      a_a0 = 8'(8'h10 + i);
      a_b0 = 8'(8'h20 + i);
      a_start = 1'(i == 4);
      #1;
      chk("b_rdy0", 32'(a_rdy0), 32'(i % 2 == 1));
      chk("b_opv", 32'(a_opv), 32'(i % 2 == 0));
      if (i >= 2) begin
        chk("b_As", 32'(a_As), 32'(8'h10 + ((i % 2 == 0) ? i - 1 : i - 2)));
        chk("b_Bs", 32'(a_Bs), 32'(8'h20 + ((i % 2 == 0) ? i - 1 : i - 2)));
      end
      chk("b_iss", a_iss, 32'(i / 2));
      chk("b_busy", 32'(a_busy), 1);
      chk("b_done", 32'(a_done), 0);
      if (a_rspv) rsp_n++;
      step();
    end
    a_v0 = 1'b0; a_start = 1'b0;
    for (int k = 0; k < 20 && !a_done; k++) begin
      if (a_rspv) rsp_n++;
      step();
    end
    chk("b_done_end", 32'(a_done), 1);
    chk("b_rsp_count", 32'(rsp_n), 4);
    chk("b_iss_end", a_iss, 4);

    // Contention on the LENGTH=6, LAT=3 instance
    b_start = 1'b1; b_res = 8'h55;
    #1;
    step();
    b_start = 1'b0;
    b_v0 = 1'b1; b_a0 = 8'hA0; b_b0 = 8'hB0;
    b_v1 = 1'b1; b_a1 = 8'hA1; b_b1 = 8'hB1;
    for (int i = 1; i <= 12; i++) begin
      #1;
      exp_iss = (i <= 1) ? 0 : ((i - 1 > 6) ? 6 : i - 1);
      chk("c_rdy0", 32'(b_rdy0), 32'(i <= 6 && i % 2 == 1));
      chk("c_rdy1", 32'(b_rdy1), 32'(i <= 6 && i % 2 == 0));
      chk("c_opv", 32'(b_opv), 32'(i >= 2 && i <= 7));
      if (i >= 2 && i <= 7) begin
        chk("c_As", 32'(b_As), (i % 2 == 0) ? 32'hA0 : 32'hA1);
        chk("c_Bs", 32'(b_Bs), (i % 2 == 0) ? 32'hB0 : 32'hB1);
      end
      chk("c_rspv", 32'(b_rspv), 32'(i >= 6 && i <= 11));
      if (i >= 6 && i <= 11) begin
        chk("c_rid", 32'(b_id), 32'((i - 6) % 2));
        chk("c_rdata", 32'(b_rdata), 32'h55);
      end
      chk("c_iss", b_iss, 32'(exp_iss));
      chk("c_busy", 32'(b_busy), 32'(i <= 11));
      chk("c_done", 32'(b_done), 32'(i == 12));
      step();
    end
    b_v0 = 1'b0; b_v1 = 1'b0;

    // Reset with three operations in flight
    b_start = 1'b1;
    #1;
    step();
    b_start = 1'b0; b_v0 = 1'b1; b_a0 = 8'h77; b_b0 = 8'h66;
    for (int i = 1; i <= 3; i++) begin
      #1;
      chk("r_rdy0", 32'(b_rdy0), 1);
      step();
    end
    b_v0 = 1'b0;
    #1;
    chk("r_iss_pre", b_iss, 3);
    chk("r_opv_pre", 32'(b_opv), 1);
    b_rst = 1'b1;
    step();
    b_rst = 1'b0; b_v0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("r_rspv", 32'(b_rspv), 0);
      chk("r_opv", 32'(b_opv), 0);
      chk("r_rdy0", 32'(b_rdy0), 0);
      chk("r_busy", 32'(b_busy), 0);
      chk("r_done", 32'(b_done), 0);
      chk("r_iss", b_iss, 0);
      chk("r_As", 32'(b_As), 0);
      chk("r_rdata", 32'(b_rdata), 0);
      step();
    end
    b_start = 1'b1;
    #1;
    step();
    b_start = 1'b0;
    #1;
    chk("r_restart_busy", 32'(b_busy), 1);
    chk("r_restart_rdy0", 32'(b_rdy0), 1);
    b_v0 = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
